// File: rtl/lsu_align_ctrl_pkg.sv
// Shared definitions for the load/store alignment controller: access-type
// encodings, controller state encoding and the access-size decoder.
package lsu_align_ctrl_pkg;

    typedef enum logic [2:0] {
        TYPE_RSVD = 3'b000,
        TYPE_LB   = 3'b001,
        TYPE_LH   = 3'b010,
        TYPE_LW   = 3'b011,
        TYPE_LD   = 3'b100,
        TYPE_LBU  = 3'b101,
        TYPE_LHU  = 3'b110,
        TYPE_LWU  = 3'b111
    } req_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Access size in bytes; 0 marks the reserved encoding.
    function automatic logic [3:0] size_bytes(input logic [2:0] req_type);
        case (req_type)
            TYPE_LB, TYPE_LBU:  size_bytes = 4'd1;
            TYPE_LH, TYPE_LHU:  size_bytes = 4'd2;
            TYPE_LW, TYPE_LWU:  size_bytes = 4'd4;
            TYPE_LD:            size_bytes = 4'd8;
            default:            size_bytes = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align_ctrl_load_merge_ext.sv
// Load-data path: stitches the one or two bus beats into the requested bytes,
// trims to the access size and sign- or zero-extends to the full width.
module load_merge_ext #(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0]             rdata0,
    input  logic [DATA_W-1:0]             rdata1,
    input  logic [$clog2(DATA_W/8)-1:0]   off,
    input  logic [2:0]                    req_type,
    output logic [DATA_W-1:0]             load_data
);
    import lsu_align_ctrl_pkg::*;

    logic [DATA_W-1:0] merged;
    logic [3:0]        size;
    logic              is_signed;
    logic              msb;

    // A shift of DATA_W (off = 0) empties rdata1, so aligned accesses ignore it.
    assign merged    = (rdata0 >> {off, 3'b000}) | (rdata1 << (DATA_W - 8 * int'(off)));
    assign size      = size_bytes(req_type);
    assign is_signed = !req_type[2] && (req_type[1:0] != 2'b00);

    // Select the sign bit of the sized value.
    always_comb begin
        case (size)
            4'd1:    msb = merged[7];
            4'd2:    msb = merged[15];
            4'd4:    msb = merged[31];
            default: msb = 1'b0;
        endcase
    end

    // Keep the sized bytes and fill everything above with the extension bit.
    always_comb begin
        load_data = '0;
        for (int i = 0; i < DATA_W; i++) begin
            load_data[i] = (i < 8 * int'(size)) ? merged[i] : (is_signed & msb);
        end
    end

endmodule

// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller: turns byte-addressed requests of any size
// into one or two bus-aligned beats, and folds the beats back into a
// single response.
module lsu_align_ctrl #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 64,
    parameter int MISALIGN_EN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_we,
    input  logic [2:0]          req_type,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic                bus_we,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_data,
    output logic                resp_err
);
    import lsu_align_ctrl_pkg::*;

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_e state_q, state_d;

    // Control registers (reset).
    logic pend_q;
    logic err_q;
    logic cross_q;

    // Captured request and read data (not reset; only observed through
    // state-gated outputs).
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [2:0]        type_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic [OFF_W-1:0]    req_off;
    logic [3:0]          req_size;
    logic                req_cross;
    logic                req_err;
    logic                accept;
    logic                beat_st;
    logic                ack_ok;
    logic [OFF_W-1:0]    off_q;
    logic [ADDR_W-1:0]   beat0_addr;
    logic [ADDR_W-1:0]   beat1_addr;
    logic [2*NB-1:0]     size_mask;
    logic [2*NB-1:0]     wstrb_sh;
    logic [2*DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0]   load_data;

    assign req_off   = req_addr[OFF_W-1:0];
    assign req_size  = size_bytes(req_type);
    assign req_cross = ({1'b0, 4'(req_off)} + {1'b0, req_size}) > 5'(NB);
    assign req_err   = (req_size == 4'd0)
                    || ((DATA_W == 32) && (req_size == 4'd8))
                    || ((MISALIGN_EN == 0) && req_cross);
    assign accept    = req_valid && req_ready;

    // An ack counts only once the current beat has been handed to the bus,
    // either earlier (pend_q) or on this very edge (bus_ready).
    assign beat_st = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
    assign ack_ok  = beat_st && bus_ack && (pend_q || bus_ready);

    assign off_q      = addr_q[OFF_W-1:0];
    assign beat0_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign beat1_addr = beat0_addr + ADDR_W'(NB);

    // Byte-enable pattern for the access size, before lane alignment.
    always_comb begin
        size_mask = '0;
        for (int i = 0; i < 2 * NB; i++) begin
            size_mask[i] = (i < int'(size_bytes(type_q)));
        end
    end

    // Double-width shifts: lower half feeds beat 0, upper half feeds beat 1.
    assign wstrb_sh = size_mask << off_q;
    assign wdata_sh = {{DATA_W{1'b0}}, wdata_q} << {off_q, 3'b000};

    load_merge_ext #(
        .DATA_W (DATA_W)
    ) u_load_merge_ext (
        .rdata0    (rdata0_q),
        .rdata1    (rdata1_q),
        .off       (off_q),
        .req_type  (type_q),
        .load_data (load_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-request control flags and the beat-handed-off flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            cross_q <= 1'b0;
        end else begin
            if (accept) begin
                err_q   <= req_err;
                cross_q <= req_cross;
            end
            if (ack_ok) begin
                pend_q <= 1'b0;
            end else if (bus_valid && bus_ready) begin
                pend_q <= 1'b1;
            end
        end
    end

    // Request capture and read-data capture per beat.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q   <= req_addr;
            we_q     <= req_we;
            type_q   <= req_type;
            wdata_q  <= req_wdata;
            rdata1_q <= '0;
        end
        if (ack_ok && (state_q == ST_BEAT0)) begin
            rdata0_q <= bus_rdata;
        end
        if (ack_ok && (state_q == ST_BEAT1)) begin
            rdata1_q <= bus_rdata;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)     state_d = req_err ? ST_RESP : ST_BEAT0;
            ST_BEAT0: if (ack_ok)     state_d = cross_q ? ST_BEAT1 : ST_RESP;
            ST_BEAT1: if (ack_ok)     state_d = ST_RESP;
            ST_RESP:  if (resp_ready) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; everything is zero outside its own state,
    // which also gives all-zero outputs while reset holds the FSM in IDLE.
    always_comb begin
        req_ready  = 1'b0;
        bus_valid  = 1'b0;
        bus_addr   = '0;
        bus_we     = 1'b0;
        bus_wdata  = '0;
        bus_wstrb  = '0;
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = rst_n;
            end
            ST_BEAT0: begin
                bus_valid = !pend_q;
                bus_addr  = beat0_addr;
                bus_we    = we_q;
                if (we_q) begin
                    bus_wdata = wdata_sh[DATA_W-1:0];
                    bus_wstrb = wstrb_sh[NB-1:0];
                end
            end
            ST_BEAT1: begin
                bus_valid = !pend_q;
                bus_addr  = beat1_addr;
                bus_we    = we_q;
                if (we_q) begin
                    bus_wdata = wdata_sh[2*DATA_W-1:DATA_W];
                    bus_wstrb = wstrb_sh[2*NB-1:NB];
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!we_q && !err_q) begin
                    resp_data = load_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Bench for lsu_align_ctrl (DATA_W=64): directed vector table, reset and
// no-split corner sequences, then randomized accesses against a byte-lane
// reference model.
module tb_lsu_align_ctrl;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [2:0]  typ;
        logic [63:0] wdata;
        logic [63:0] rd0;
        logic [63:0] rd1;
        logic        err;
        int          nbeats;
        logic [63:0] addr0;
        logic [63:0] addr1;
        logic [7:0]  strb0;
        logic [7:0]  strb1;
        logic [63:0] wd0;
        logic [63:0] wd1;
        logic [63:0] data;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [63:0] req_addr, req_wdata;
    logic [2:0]  req_type;
    logic        bus_valid, bus_ready, bus_we, bus_ack;
    logic [63:0] bus_addr, bus_wdata, bus_rdata;
    logic [7:0]  bus_wstrb;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_data;

    logic        n_req_valid, n_req_ready, n_req_we;
    logic [63:0] n_req_addr, n_req_wdata;
    logic [2:0]  n_req_type;
    logic        n_bus_valid, n_bus_ready, n_bus_we, n_bus_ack;
    logic [63:0] n_bus_addr, n_bus_wdata, n_bus_rdata;
    logic [7:0]  n_bus_wstrb;
    logic        n_resp_valid, n_resp_ready, n_resp_err;
    logic [63:0] n_resp_data;

    int n_cmp  = 0;
    int n_fail = 0;

    lsu_align_ctrl #(.DATA_W(64), .ADDR_W(64), .MISALIGN_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_type(req_type), .req_wdata(req_wdata),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err)
    );

    lsu_align_ctrl #(.DATA_W(64), .ADDR_W(64), .MISALIGN_EN(0)) dut_nm (
        .clk(clk), .rst_n(rst_n),
        .req_valid(n_req_valid), .req_ready(n_req_ready), .req_addr(n_req_addr),
        .req_we(n_req_we), .req_type(n_req_type), .req_wdata(n_req_wdata),
        .bus_valid(n_bus_valid), .bus_ready(n_bus_ready), .bus_addr(n_bus_addr),
        .bus_we(n_bus_we), .bus_wdata(n_bus_wdata), .bus_wstrb(n_bus_wstrb),
        .bus_ack(n_bus_ack), .bus_rdata(n_bus_rdata),
        .resp_valid(n_resp_valid), .resp_ready(n_resp_ready),
        .resp_data(n_resp_data), .resp_err(n_resp_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] addr, input logic we, input logic [2:0] typ,
                                input logic [63:0] wdata, input logic [63:0] rd0, input logic [63:0] rd1,
                                input logic err, input int nb, input logic [63:0] a0, input logic [63:0] a1,
                                input logic [7:0] s0, input logic [7:0] s1, input logic [63:0] w0,
                                input logic [63:0] w1, input logic [63:0] data);
        vec_t v;
        v.addr = addr; v.we = we; v.typ = typ; v.wdata = wdata; v.rd0 = rd0; v.rd1 = rd1;
        v.err = err; v.nbeats = nb; v.addr0 = a0; v.addr1 = a1; v.strb0 = s0; v.strb1 = s1;
        v.wd0 = w0; v.wd1 = w1; v.data = data;
        return v;
    endfunction

    // Reference: treat the two beats as a 16-byte lane window and move bytes.
    function automatic vec_t ref_model(input vec_t v);
        vec_t        r;
        int          sz;
        int          off;
        logic [7:0]  lane [16];
        logic [15:0] sm;
        logic [63:0] val;
        r   = v;
        sz  = (v.typ == 3'b000) ? 0 : ((v.typ[1:0] == 2'b00) ? 8 : (1 << (int'(v.typ[1:0]) - 1)));
        off = int'(v.addr % 64'd8);
        r.err    = (sz == 0);
        r.nbeats = r.err ? 0 : ((off + sz > 8) ? 2 : 1);
        r.addr0  = v.addr - 64'(off);
        r.addr1  = r.addr0 + 64'd8;
        for (int i = 0; i < 16; i++) lane[i] = 8'h00;
        sm  = '0;
        val = '0;
        if (v.we) begin
            for (int i = 0; i < 8; i++) lane[off + i] = v.wdata[8*i +: 8];
            for (int j = 0; j < sz; j++) sm[off + j] = 1'b1;
            r.data = '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                lane[i]     = v.rd0[8*i +: 8];
                lane[8 + i] = v.rd1[8*i +: 8];
            end
            for (int i = 0; i < sz; i++) val[8*i +: 8] = lane[off + i];
            if (!v.typ[2] && sz > 0 && sz < 8 && val[8*sz - 1])
                val = val | ~((64'd1 << (8 * sz)) - 64'd1);
            r.data = val;
        end
        for (int i = 0; i < 8; i++) begin
            r.wd0[8*i +: 8] = lane[i];
            r.wd1[8*i +: 8] = lane[8 + i];
        end
        if (!v.we) begin
            r.wd0 = '0;
            r.wd1 = '0;
        end
        r.strb0 = sm[7:0];
        r.strb1 = sm[15:8];
        return r;
    endfunction

    // Drive one request and act as the bus slave; checks beat contents,
    // exact cycle timing, ignored early acks, and response hold.
    task automatic run_access(input vec_t v, input int rdy_dly, input int ack_dly,
                              input int rsp_dly, input string tag);
        logic [63:0] ea;
        @(negedge clk);
        chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_addr = v.addr; req_we = v.we; req_type = v.typ; req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        for (int b = 0; b < v.nbeats; b++) begin
            ea = (b == 0) ? v.addr0 : v.addr1;
            chk($sformatf("%s b%0d bus_valid", tag, b), 64'(bus_valid), 64'd1);
            chk($sformatf("%s b%0d bus_addr", tag, b), bus_addr, ea);
            chk($sformatf("%s b%0d bus_we", tag, b), 64'(bus_we), 64'(v.we));
            if (v.we) begin
                chk($sformatf("%s b%0d wstrb", tag, b), 64'(bus_wstrb), 64'((b == 0) ? v.strb0 : v.strb1));
                chk($sformatf("%s b%0d wdata", tag, b), bus_wdata, (b == 0) ? v.wd0 : v.wd1);
            end
            for (int d = 0; d < rdy_dly; d++) begin
                bus_ack   = 1'($urandom_range(0, 1));
                bus_rdata = {$urandom, $urandom};
                @(negedge clk);
                bus_ack = 1'b0;
                chk($sformatf("%s b%0d hold valid", tag, b), 64'(bus_valid), 64'd1);
                chk($sformatf("%s b%0d hold addr", tag, b), bus_addr, ea);
            end
            bus_ready = 1'b1;
            if (ack_dly == 0) begin
                bus_ack   = 1'b1;
                bus_rdata = (b == 0) ? v.rd0 : v.rd1;
            end
            @(negedge clk);
            bus_ready = 1'b0;
            bus_ack   = 1'b0;
            if (ack_dly > 0) begin
                chk($sformatf("%s b%0d valid drop", tag, b), 64'(bus_valid), 64'd0);
                for (int d = 1; d < ack_dly; d++) @(negedge clk);
                bus_ack   = 1'b1;
                bus_rdata = (b == 0) ? v.rd0 : v.rd1;
                @(negedge clk);
                bus_ack = 1'b0;
            end
        end
        chk({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
        chk({tag, " no bus_valid"}, 64'(bus_valid), 64'd0);
        chk({tag, " resp_err"}, 64'(resp_err), 64'(v.err));
        if (!v.err) chk({tag, " resp_data"}, resp_data, v.data);
        for (int d = 0; d < rsp_dly; d++) begin
            @(negedge clk);
            chk({tag, " resp hold"}, 64'(resp_valid), 64'd1);
            if (!v.err) chk({tag, " resp_data hold"}, resp_data, v.data);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, " resp done"}, 64'(resp_valid), 64'd0);
    endtask

    // No-split instance: request must go straight to an error response.
    task automatic nm_err(input logic [63:0] a, input logic [2:0] t, input string tag);
        @(negedge clk);
        n_req_valid = 1'b1; n_req_addr = a; n_req_type = t; n_req_we = 1'b0;
        @(negedge clk);
        n_req_valid = 1'b0;
        chk({tag, " no bus_valid"}, 64'(n_bus_valid), 64'd0);
        chk({tag, " resp_valid"}, 64'(n_resp_valid), 64'd1);
        chk({tag, " resp_err"}, 64'(n_resp_err), 64'd1);
        n_resp_ready = 1'b1;
        @(negedge clk);
        n_resp_ready = 1'b0;
        chk({tag, " resp done"}, 64'(n_resp_valid), 64'd0);
    endtask

    vec_t tbl [11];
    vec_t v;

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req_addr = 0; req_we = 0; req_type = 0; req_wdata = 0;
        bus_ready = 0; bus_ack = 0; bus_rdata = 0; resp_ready = 0;
        n_req_valid = 0; n_req_addr = 0; n_req_we = 0; n_req_type = 0; n_req_wdata = 0;
        n_bus_ready = 0; n_bus_ack = 0; n_bus_rdata = 0; n_resp_ready = 0;

        tbl[0]  = mk(64'h1003, 0, 3'b001, 0, 64'h0000_0000_8000_0000, 0, 0, 1, 64'h1000, 64'h1008,
                     8'h00, 8'h00, 0, 0, 64'hFFFF_FFFF_FFFF_FF80);
        tbl[1]  = mk(64'h1006, 0, 3'b110, 0, 64'hBEEF_0000_0000_0000, 0, 0, 1, 64'h1000, 64'h1008,
                     8'h00, 8'h00, 0, 0, 64'h0000_0000_0000_BEEF);
        tbl[2]  = mk(64'h1006, 0, 3'b011, 0, 64'hAABB_0000_0000_0000, 64'h0000_0000_0000_CCDD, 0, 2,
                     64'h1000, 64'h1008, 8'h00, 8'h00, 0, 0, 64'hFFFF_FFFF_CCDD_AABB);
        tbl[3]  = mk(64'h100E, 1, 3'b011, 64'h1122_3344, 0, 0, 0, 2, 64'h1008, 64'h1010,
                     8'hC0, 8'h03, 64'h3344_0000_0000_0000, 64'h0000_0000_0000_1122, 0);
        tbl[4]  = mk(64'h1000, 0, 3'b000, 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        tbl[5]  = mk(64'h2000, 0, 3'b100, 0, 64'h8123_4567_89AB_CDEF, 0, 0, 1, 64'h2000, 64'h2008,
                     8'h00, 8'h00, 0, 0, 64'h8123_4567_89AB_CDEF);
        tbl[6]  = mk(64'h2004, 0, 3'b111, 0, 64'h8765_4321_0000_0000, 0, 0, 1, 64'h2000, 64'h2008,
                     8'h00, 8'h00, 0, 0, 64'h0000_0000_8765_4321);
        tbl[7]  = mk(64'h3003, 1, 3'b100, 64'h0102_0304_0506_0708, 0, 0, 0, 2, 64'h3000, 64'h3008,
                     8'hF8, 8'h07, 64'h0405_0607_0800_0000, 64'h0000_0000_0001_0203, 0);
        tbl[8]  = mk(64'h1007, 0, 3'b010, 0, 64'h7F00_0000_0000_0000, 64'h0000_0000_0000_0080, 0, 2,
                     64'h1000, 64'h1008, 8'h00, 8'h00, 0, 0, 64'hFFFF_FFFF_FFFF_807F);
        tbl[9]  = mk(64'h4005, 1, 3'b001, 64'hAB, 0, 0, 0, 1, 64'h4000, 64'h4008,
                     8'h20, 8'h00, 64'h0000_AB00_0000_0000, 0, 0);
        tbl[10] = mk(64'h1003, 0, 3'b001, 0, 64'h0000_0000_7F00_0000, 0, 0, 1, 64'h1000, 64'h1008,
                     8'h00, 8'h00, 0, 0, 64'h0000_0000_0000_007F);

        // Outputs while reset is held.
        #3;
        chk("rst req_ready", 64'(req_ready), 64'd0);
        chk("rst bus_valid", 64'(bus_valid), 64'd0);
        chk("rst resp_valid", 64'(resp_valid), 64'd0);
        chk("rst resp_err", 64'(resp_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++)
            run_access(tbl[i], i % 2, i % 3, i % 2, $sformatf("vec%0d", i));

        // Reset while the second beat of a split store awaits its ack.
        @(negedge clk);
        req_valid = 1'b1; req_addr = tbl[3].addr; req_we = 1'b1; req_type = tbl[3].typ;
        req_wdata = tbl[3].wdata;
        @(negedge clk);
        req_valid = 1'b0;
        bus_ready = 1'b1; bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("rstseq beat1 addr", bus_addr, 64'h1010);
        @(negedge clk);
        bus_ready = 1'b0;
        chk("rstseq wait ack", 64'(bus_valid), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rstseq req_ready", 64'(req_ready), 64'd0);
        chk("rstseq bus_valid", 64'(bus_valid), 64'd0);
        chk("rstseq bus_addr", bus_addr, 64'd0);
        chk("rstseq bus_we", 64'(bus_we), 64'd0);
        chk("rstseq bus_wdata", bus_wdata, 64'd0);
        chk("rstseq bus_wstrb", 64'(bus_wstrb), 64'd0);
        chk("rstseq resp_valid", 64'(resp_valid), 64'd0);
        chk("rstseq resp_data", resp_data, 64'd0);
        chk("rstseq resp_err", 64'(resp_err), 64'd0);
        @(negedge clk);
        bus_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("rstseq idle req_ready", 64'(req_ready), 64'd1);
        chk("rstseq idle bus_valid", 64'(bus_valid), 64'd0);
        chk("rstseq idle resp_valid", 64'(resp_valid), 64'd0);
        run_access(tbl[0], 0, 0, 0, "post-rst lb");

        // No-split instance: crossing and reserved accesses error out.
        nm_err(64'h1006, 3'b011, "nm lw cross");
        nm_err(64'h1000, 3'b000, "nm rsvd");
        @(negedge clk);
        n_req_valid = 1'b1; n_req_addr = 64'h1004; n_req_type = 3'b011;
        @(negedge clk);
        n_req_valid = 1'b0;
        chk("nm lw aligned bus_valid", 64'(n_bus_valid), 64'd1);
        n_bus_ready = 1'b1; n_bus_ack = 1'b1; n_bus_rdata = 64'h1234_5678_0000_0000;
        @(negedge clk);
        n_bus_ready = 1'b0; n_bus_ack = 1'b0;
        chk("nm lw aligned resp_err", 64'(n_resp_err), 64'd0);
        chk("nm lw aligned resp_data", n_resp_data, 64'h0000_0000_1234_5678);
        n_resp_ready = 1'b1;
        @(negedge clk);
        n_resp_ready = 1'b0;

        // Randomized accesses against the byte-lane model.
        for (int k = 0; k < 200; k++) begin
            v.addr  = {$urandom, $urandom};
            v.we    = 1'($urandom_range(0, 1));
            v.typ   = 3'($urandom_range(0, 7));
            v.wdata = {$urandom, $urandom};
            v.rd0   = {$urandom, $urandom};
            v.rd1   = {$urandom, $urandom};
            v = ref_model(v);
            run_access(v, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                       $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
